// File: rtl/crc_sched.sv
`timescale 1ns/1ps
// crc_sched: round-robin scheduler that lets two requesters share one memory read
// port and one CRC engine, walking each job's address range and capturing the result.
module crc_sched (
    input  logic        i_clk50m,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req_start,
    input  logic [9:0]  i_req0_base,
    input  logic [9:0]  i_req1_base,
    input  logic [10:0] i_req0_len,
    input  logic [10:0] i_req1_len,
    input  logic [15:0] i_crc_val,
    output logic [1:0]  o_req_ack,
    output logic [9:0]  o_mem_addr_out,
    output logic        o_crc_clr,
    output logic        o_crc_en,
    output logic [15:0] o_crc_res,
    output logic        o_crc_id,
    output logic        o_crc_rdy,
    output logic        o_crc_err,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_rr_last;
    logic        r_job_id;
    logic        r_job_err;
    logic [10:0] r_remain;
    logic [9:0]  r_addr;
    logic [1:0]  r_ack;
    logic        r_clr;
    logic        r_en;
    logic        r_rdy;
    logic        r_err_out;
    logic        r_busy;
    logic [15:0] r_res;
    logic        r_res_id;

    logic        w_rr_next;
    logic        w_job_id_next;
    logic        w_job_err_next;
    logic [10:0] w_remain_next;
    logic [9:0]  w_addr_next;
    logic [1:0]  w_ack_next;
    logic        w_clr_next;
    logic        w_en_next;
    logic        w_rdy_next;
    logic        w_err_out_next;
    logic [15:0] w_res_next;
    logic        w_res_id_next;

    logic        w_gnt_id;
    logic [9:0]  w_gnt_base;
    logic [10:0] w_gnt_len;
    logic        w_len_ok;

    // Contention goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        if (i_req_start == 2'b11) begin
            w_gnt_id = ~r_rr_last;
        end else begin
            w_gnt_id = i_req_start[1];
        end
        w_gnt_base = w_gnt_id ? i_req1_base : i_req0_base;
        w_gnt_len  = w_gnt_id ? i_req1_len  : i_req0_len;
        w_len_ok   = (w_gnt_len != 11'd0) && (w_gnt_len <= 11'd1024);
    end

    always_comb begin
        w_state_next   = r_state;
        w_rr_next      = r_rr_last;
        w_job_id_next  = r_job_id;
        w_job_err_next = r_job_err;
        w_remain_next  = r_remain;
        w_addr_next    = r_addr;
        w_ack_next     = 2'b00;
        w_clr_next     = 1'b0;
        w_en_next      = 1'b0;
        w_rdy_next     = 1'b0;
        w_err_out_next = 1'b0;
        w_res_next     = r_res;
        w_res_id_next  = r_res_id;

        case (r_state)
            S_IDLE: begin
                if (i_req_start != 2'b00) begin
                    w_rr_next      = w_gnt_id;
                    w_job_id_next  = w_gnt_id;
                    w_ack_next     = w_gnt_id ? 2'b10 : 2'b01;
                    w_job_err_next = ~w_len_ok;
                    if (w_len_ok) begin
                        w_state_next  = S_CLR;
                        w_clr_next    = 1'b1;
                        w_addr_next   = w_gnt_base;
                        w_remain_next = w_gnt_len;
                    end else begin
                        // Illegal length: skip straight to the result handshake.
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_CLR: begin
                w_state_next = S_READ;
                w_en_next    = 1'b1;
                w_addr_next  = r_addr + 10'd1;
            end
            S_READ: begin
                w_remain_next = r_remain - 11'd1;
                if (r_remain == 11'd1) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_en_next   = 1'b1;
                    w_addr_next = r_addr + 10'd1;
                end
            end
            S_WAIT: begin
                w_state_next   = S_DONE;
                w_rdy_next     = 1'b1;
                w_err_out_next = r_job_err;
                w_res_id_next  = r_job_id;
                if (!r_job_err) begin
                    w_res_next = i_crc_val;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            r_job_id  <= 1'b0;
            r_job_err <= 1'b0;
            r_remain  <= 11'd0;
            r_addr    <= 10'd0;
            r_ack     <= 2'b00;
            r_clr     <= 1'b0;
            r_en      <= 1'b0;
            r_rdy     <= 1'b0;
            r_err_out <= 1'b0;
            r_busy    <= 1'b0;
            r_res     <= 16'd0;
            r_res_id  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rr_last <= w_rr_next;
            r_job_id  <= w_job_id_next;
            r_job_err <= w_job_err_next;
            r_remain  <= w_remain_next;
            r_addr    <= w_addr_next;
            r_ack     <= w_ack_next;
            r_clr     <= w_clr_next;
            r_en      <= w_en_next;
            r_rdy     <= w_rdy_next;
            r_err_out <= w_err_out_next;
            r_busy    <= (w_state_next != S_IDLE);
            r_res     <= w_res_next;
            r_res_id  <= w_res_id_next;
        end
    end

    assign o_req_ack      = r_ack;
    assign o_mem_addr_out = r_addr;
    assign o_crc_clr      = r_clr;
    assign o_crc_en       = r_en;
    assign o_crc_res      = r_res;
    assign o_crc_id       = r_res_id;
    assign o_crc_rdy      = r_rdy;
    assign o_crc_err      = r_err_out;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_crc_sched.sv
`timescale 1ns/1ps
// Directed bench for crc_sched: behavioural 1-cycle memory and CRC-16 engine around
// the DUT, expected acks/results queued when requests are driven, popped on output.
module tb_crc_sched;

    logic        clk50m = 1'b0;
    logic        rst_n  = 1'b1;
    logic [1:0]  req_start = 2'b00;
    logic [9:0]  req0_base = '0;
    logic [9:0]  req1_base = '0;
    logic [10:0] req0_len  = '0;
    logic [10:0] req1_len  = '0;
    logic [15:0] crc_val;
    logic [1:0]  req_ack;
    logic [9:0]  mem_addr;
    logic        crc_clr, crc_en, crc_id, crc_rdy, crc_err, busy;
    logic [15:0] crc_res;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [15:0] mem [1024];
    logic [15:0] mem_q;
    logic [1:0]  ack_q [$];
    logic [17:0] res_q [$];
    logic [17:0] mon_e;
    logic [15:0] last_res = '0;
    logic [9:0]  exp_addr = '0;

    crc_sched dut (
        .i_clk50m       (clk50m),
        .i_rst_n        (rst_n),
        .i_req_start    (req_start),
        .i_req0_base    (req0_base),
        .i_req1_base    (req1_base),
        .i_req0_len     (req0_len),
        .i_req1_len     (req1_len),
        .i_crc_val      (crc_val),
        .o_req_ack      (req_ack),
        .o_mem_addr_out (mem_addr),
        .o_crc_clr      (crc_clr),
        .o_crc_en       (crc_en),
        .o_crc_res      (crc_res),
        .o_crc_id       (crc_id),
        .o_crc_rdy      (crc_rdy),
        .o_crc_err      (crc_err),
        .o_busy         (busy)
    );

    always #10 clk50m = ~clk50m;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 15; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_crc(input logic [9:0] base, input logic [10:0] len);
        logic [15:0] c;
        logic [9:0]  a;
        c = 16'hFFFF;
        a = base;
        for (int i = 0; i < int'(len); i++) begin
            c = crc_step(c, mem[a]);
            a = a + 10'd1;
        end
        return c;
    endfunction

    always @(posedge clk50m) cyc <= cyc + 1;
    always @(posedge clk50m) mem_q <= mem[mem_addr];
    always @(posedge clk50m) begin
        if (crc_clr)     crc_val <= 16'hFFFF;
        else if (crc_en) crc_val <= crc_step(crc_val, mem_q);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop on every ack / result the DUT produces.
    always @(negedge clk50m) begin
        if (rst_n) begin
            if (req_ack != 2'b00) begin
                if (ack_q.size() == 0) check("ack_unexpected", 32'(req_ack), 32'd0);
                else                   check("ack_order", 32'(req_ack), 32'(ack_q.pop_front()));
            end
            if (crc_rdy) begin
                if (res_q.size() == 0) begin
                    check("rdy_unexpected", 32'(crc_rdy), 32'd0);
                end else begin
                    mon_e = res_q.pop_front();
                    check("crc_err", 32'(crc_err), 32'(mon_e[17]));
                    check("crc_id", 32'(crc_id), 32'(mon_e[16]));
                    check("crc_res", 32'(crc_res), 32'(mon_e[15:0]));
                end
            end else begin
                check("err_without_rdy", 32'(crc_err), 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ack"},  32'(req_ack),  32'd0);
        check({pfx, "_clr"},  32'(crc_clr),  32'd0);
        check({pfx, "_en"},   32'(crc_en),   32'd0);
        check({pfx, "_rdy"},  32'(crc_rdy),  32'd0);
        check({pfx, "_err"},  32'(crc_err),  32'd0);
        check({pfx, "_busy"}, 32'(busy),     32'd0);
        check({pfx, "_addr"}, 32'(mem_addr), 32'd0);
        check({pfx, "_res"},  32'(crc_res),  32'd0);
        check({pfx, "_id"},   32'(crc_id),   32'd0);
    endtask

    task automatic run_job(input logic id, input logic [9:0] base, input logic [10:0] len);
        logic ok;
        logic got;
        int   ack_cyc, en_cnt, addr_bad, busy_low;
        ok = (len != 11'd0) && (len <= 11'd1024);
        if (id) begin req1_base = base; req1_len = len; end
        else    begin req0_base = base; req0_len = len; end
        ack_q.push_back(id ? 2'b10 : 2'b01);
        res_q.push_back({~ok, id, ok ? exp_crc(base, len) : last_res});
        if (ok) last_res = exp_crc(base, len);
        req_start[id] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk50m);
            got = req_ack[id];
        end
        req_start[id] = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
        if (!got) return;
        ack_cyc = cyc;
        check("clr_with_ack", 32'(crc_clr), 32'(ok));
        check("addr_at_ack", 32'(mem_addr), 32'(ok ? base : exp_addr));
        // Inputs change mid-job; the latched copy must govern.
        if (id) begin req1_base = 10'($urandom); req1_len = 11'($urandom_range(1, 1024)); end
        else    begin req0_base = 10'($urandom); req0_len = 11'($urandom_range(1, 1024)); end
        en_cnt = 0; addr_bad = 0; busy_low = 0; got = 1'b0;
        for (int n = 0; n < 1100 && !got; n++) begin
            @(negedge clk50m);
            if (crc_en) begin
                if (mem_addr !== base + 10'(en_cnt + 1)) addr_bad++;
                en_cnt++;
            end
            if (!busy) busy_low++;
            got = crc_rdy;
        end
        if (ok) exp_addr = base + 10'(len);
        check("rdy_seen", 32'(got), 32'd1);
        check("en_cycles", 32'(en_cnt), ok ? 32'(len) : 32'd0);
        check("addr_seq", 32'(addr_bad), 32'd0);
        check("busy_low", 32'(busy_low), 32'd0);
        check("latency", 32'(cyc - ack_cyc), ok ? 32'(int'(len) + 2) : 32'd1);
        check("addr_hold", 32'(mem_addr), 32'(exp_addr));
        @(negedge clk50m);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 2000 && (res_q.size() != 0 || ack_q.size() != 0); n++)
            @(negedge clk50m);
        check("queue_drained", 32'(res_q.size() + ack_q.size()), 32'd0);
    endtask

    initial begin
        int   n_acks;
        int   bad;
        logic got;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        repeat (3) @(posedge clk50m);
        @(negedge clk50m);
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk50m);

        run_job(1'b0, 10'd0, 11'd4);
        run_job(1'b1, 10'd1022, 11'd4);

        // Both held with len 2: after requester 1 was last, grants go 0,1,0,1.
        req0_base = 10'd100; req0_len = 11'd2;
        req1_base = 10'd200; req1_len = 11'd2;
        for (int k = 0; k < 4; k++) begin
            ack_q.push_back((k % 2) ? 2'b10 : 2'b01);
            res_q.push_back({1'b0, 1'(k % 2), exp_crc((k % 2) ? 10'd200 : 10'd100, 11'd2)});
        end
        last_res = exp_crc(10'd200, 11'd2);
        exp_addr = 10'd202;
        req_start = 2'b11;
        n_acks = 0;
        for (int n = 0; n < 100 && n_acks < 4; n++) begin
            @(negedge clk50m);
            if (req_ack != 2'b00) n_acks++;
        end
        req_start = 2'b00;
        check("arb_acks", 32'(n_acks), 32'd4);
        wait_drain();
        repeat (2) @(negedge clk50m);

        run_job(1'b0, 10'd5, 11'd0);
        run_job(1'b0, 10'd7, 11'd1025);
        run_job(1'b1, 10'd500, 11'd1);
        run_job(1'b0, 10'd0, 11'd1024);

        // Reset in the middle of a 100-word job: abort with no result.
        req0_base = 10'd50; req0_len = 11'd100;
        ack_q.push_back(2'b01);
        req_start[0] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk50m);
            got = req_ack[0];
        end
        req_start[0] = 1'b0;
        check("midrst_ack_seen", 32'(got), 32'd1);
        repeat (20) @(negedge clk50m);
        check("midrst_in_read", 32'(crc_en), 32'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk50m);
        @(posedge clk50m);
        @(negedge clk50m);
        rst_n = 1'b1;
        last_res = '0;
        exp_addr = '0;
        bad = 0;
        repeat (5) begin
            @(negedge clk50m);
            if (busy || crc_rdy) bad++;
        end
        check("idle_after_rst", 32'(bad), 32'd0);

        run_job(1'b1, 10'd300, 11'd3);
        run_job(1'b0, 10'd9, 11'd0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
